onchip_ram_pipe: RTL and testbench

ONCHIP_RAM_PIPE -- requirements
Module: onchip_ram_pipe

---
 rtl/onchip_ram_pipe.sv | 154 +++++++++++++++
 tb/tb_onchip_ram_pipe.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_ram_pipe.sv
`timescale 1ns/1ps
// onchip_ram_pipe: single-port on-chip RAM with an Avalon-MM slave interface, byte-lane
// writes, a fully pipelined read path of 1 or 2 cycles, and an error response for
// out-of-range words.
//
// Optional feature (compile-time macro ONCHIP_RAM_INIT_CLEAR_EN): when defined, a clear
// state machine zero-fills the whole array after every reset release. During the fill
// waitrequest and busy are high. When undefined, the block is ready right after reset and
// the array holds whatever it powered up with until written.
//
// Ports:
//   clk, reset_n      sole clock, asynchronous active-low reset
//   chipselect, read, write, address, byteenable, writedata
//                     Avalon-MM command; a write wins if read and write are both high
//   readdata, readdatavalid, response
//                     read return, READ_LATENCY cycles after acceptance (00 OKAY, 10 SLVERR)
//   waitrequest       stall, high only while the clear runs
//   clken             global clock enable; all state holds when low
//   busy              clear in progress
module onchip_ram_pipe #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 10000,
  parameter int unsigned ADDR_WIDTH   = 14,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic [DATA_WIDTH-1:0]   writedata,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest,
  output logic [1:0]              response,
  input  logic                    clken,
  output logic                    busy
);

  localparam int unsigned NumBytes   = DATA_WIDTH / 8;
  localparam int unsigned IdxW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlvErr = 2'b10;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  accept, wr_accept, rd_accept, in_range;
  logic [IdxW-1:0]       idx;
  logic                  clr_we;
  logic [IdxW-1:0]       clr_idx;

  assign in_range  = (32'(address) < DEPTH);
  assign idx       = address[IdxW-1:0];
  assign accept    = chipselect & (read | write) & ~waitrequest & clken;
  assign wr_accept = accept & write;
  // A combined read+write is treated purely as a write.
  assign rd_accept = accept & read & ~write;

`ifdef ONCHIP_RAM_INIT_CLEAR_EN
  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e          state_q;
  logic [IdxW-1:0] clr_cnt_q;
  logic            busy_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StClear;
      clr_cnt_q <= '0;
      busy_q    <= 1'b1;
    end else if (clken) begin
      unique case (state_q)
        StClear: begin
          if (clr_cnt_q == IdxW'(DEPTH - 1)) begin
            state_q <= StReady;
            busy_q  <= 1'b0;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        StReady: ;
      endcase
    end
  end

  assign clr_we      = (state_q == StClear) & clken;
  assign clr_idx     = clr_cnt_q;
  assign waitrequest = busy_q;
  assign busy        = busy_q;
`else
  assign clr_we      = 1'b0;
  assign clr_idx     = '0;
  assign waitrequest = 1'b0;
  assign busy        = 1'b0;
`endif

  // Array and its synchronous read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (clken) begin
      if (clr_we) begin
        mem[clr_idx] <= '0;
      end else if (wr_accept && in_range) begin
        for (int b = 0; b < NumBytes; b++) begin
          if (byteenable[b]) mem[idx][8*b +: 8] <= writedata[8*b +: 8];
        end
      end
      if (rd_accept && in_range) ram_q <= mem[idx];
    end
  end

  logic                  s1_valid_q, s1_err_q;
  logic [DATA_WIDTH-1:0] s1_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
    end else if (clken) begin
      s1_valid_q <= rd_accept;
      s1_err_q   <= rd_accept & ~in_range;
    end
  end

  // Gate the unreset RAM register so reset and error reads present zero data.
  assign s1_data = (s1_valid_q && !s1_err_q) ? ram_q : '0;

  if (READ_LATENCY >= 2) begin : g_lat2
    logic                  s2_valid_q, s2_err_q;
    logic [DATA_WIDTH-1:0] s2_data_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        s2_valid_q <= 1'b0;
        s2_err_q   <= 1'b0;
        s2_data_q  <= '0;
      end else if (clken) begin
        s2_valid_q <= s1_valid_q;
        s2_err_q   <= s1_err_q;
        s2_data_q  <= s1_data;
      end
    end

    assign readdatavalid = s2_valid_q;
    assign readdata      = s2_data_q;
    assign response      = s2_err_q ? RespSlvErr : RespOkay;
  end else begin : g_lat1
    assign readdatavalid = s1_valid_q;
    assign readdata      = s1_data;
    assign response      = s1_err_q ? RespSlvErr : RespOkay;
  end

endmodule

// File: tb/tb_onchip_ram_pipe.sv
`timescale 1ns/1ps
// Directed bench for onchip_ram_pipe. Two instances share all inputs: u_dut1 with read
// latency 1 and u_dut2 with read latency 2. Inputs change 1 ns after each rising edge and
// outputs are sampled at the same point, so a command driven before edge E is accepted
// at E and latency-1 data is visible right after E.
module tb_onchip_ram_pipe;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 10000;
  localparam int unsigned AW    = 14;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          chipselect = 1'b0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic          clken = 1'b1;
  logic [AW-1:0] address = '0;
  logic [3:0]    byteenable = '0;
  logic [DW-1:0] writedata = '0;

  logic [DW-1:0] rdata1, rdata2;
  logic          rvalid1, rvalid2, wait1, wait2, busy1, busy2;
  logic [1:0]    resp1, resp2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  onchip_ram_pipe #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .READ_LATENCY(1)
  ) u_dut1 (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .read(read), .write(write),
    .address(address), .byteenable(byteenable), .writedata(writedata),
    .readdata(rdata1), .readdatavalid(rvalid1), .waitrequest(wait1), .response(resp1),
    .clken(clken), .busy(busy1)
  );

  onchip_ram_pipe #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .READ_LATENCY(2)
  ) u_dut2 (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .read(read), .write(write),
    .address(address), .byteenable(byteenable), .writedata(writedata),
    .readdata(rdata2), .readdatavalid(rvalid2), .waitrequest(wait2), .response(resp2),
    .clken(clken), .busy(busy2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    chipselect = 1'b1; write = 1'b1; read = 1'b0;
    address = a; writedata = d; byteenable = be;
    step();
    idle();
  endtask

  // Single read: latency-1 result right after the accept edge, latency-2 one edge later.
  task automatic rd_check(input string tag, input logic [AW-1:0] a, input logic [31:0] exp_d,
                          input logic [1:0] exp_r);
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
    step();
    idle();
    check_eq({tag, "_v1"}, rvalid1, 1);
    check_eq({tag, "_d1"}, rdata1, exp_d);
    check_eq({tag, "_r1"}, resp1, exp_r);
    check_eq({tag, "_v2early"}, rvalid2, 0);
    step();
    check_eq({tag, "_v1off"}, rvalid1, 0);
    check_eq({tag, "_v2"}, rvalid2, 1);
    check_eq({tag, "_d2"}, rdata2, exp_d);
    check_eq({tag, "_r2"}, resp2, exp_r);
  endtask

  // Cycles spent busy, bounded so a stuck clear still reaches the summary.
  task automatic count_busy(output int n);
    n = 0;
    while (busy1 && n < 3 * DEPTH) begin
      step();
      n++;
    end
  endtask

  logic [31:0] pd [3];

  initial begin
    int n;
    pd[0] = 32'hA0A0_A0A0;
    pd[1] = 32'hB1B1_B1B1;
    pd[2] = 32'hC2C2_C2C2;

    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_v1", rvalid1, 0);
    check_eq("rst_d1", rdata1, 0);
    check_eq("rst_r1", resp1, 0);
    check_eq("rst_v2", rvalid2, 0);
    check_eq("rst_d2", rdata2, 0);
    check_eq("rst_r2", resp2, 0);
    reset_n = 1'b1;

`ifdef ONCHIP_RAM_INIT_CLEAR_EN
    check_eq("clr_busy0", busy1, 1);
    check_eq("clr_wait0", wait1, 1);
    count_busy(n);
    check_eq("clr_cycles", n, DEPTH);
    check_eq("clr_wait_done", wait1, 0);
    check_eq("clr_busy2_done", busy2, 0);
    rd_check("clr_rd5", 5, 32'h0, 2'b00);
`else
    check_eq("rdy_wait1", wait1, 0);
    check_eq("rdy_busy1", busy1, 0);
    check_eq("rdy_wait2", wait2, 0);
`endif

    // Byte lanes
    wr(3, 32'hAABB_CCDD, 4'b1111);
    wr(3, 32'h1122_3344, 4'b0101);
    rd_check("lanes", 3, 32'hAA22_CC44, 2'b00);

    // Read on N, write same word on N+1: read sees the old data
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = 3;
    step();
    check_eq("rw_d1", rdata1, 32'hAA22_CC44);
    read = 1'b0; write = 1'b1; writedata = 32'h5566_7788; byteenable = 4'b1111;
    step();
    idle();
    check_eq("rw_v2", rvalid2, 1);
    check_eq("rw_d2", rdata2, 32'hAA22_CC44);
    rd_check("rw_new", 3, 32'h5566_7788, 2'b00);

    // Read and write together: write only, no read return
    chipselect = 1'b1; read = 1'b1; write = 1'b1; address = 7;
    writedata = 32'h0BAD_CAFE; byteenable = 4'b1111;
    step();
    idle();
    check_eq("prio_v1", rvalid1, 0);
    step();
    check_eq("prio_v2", rvalid2, 0);
    rd_check("prio", 7, 32'h0BAD_CAFE, 2'b00);

    // Back-to-back reads of 0,1,2
    for (int i = 0; i < 3; i++) wr(AW'(i), pd[i], 4'b1111);
    for (int k = 0; k < 5; k++) begin
      if (k < 3) begin
        chipselect = 1'b1; read = 1'b1; write = 1'b0; address = AW'(k);
      end else begin
        idle();
      end
      step();
      check_eq($sformatf("pipe_v1_%0d", k), rvalid1, (k < 3) ? 1 : 0);
      if (k < 3) check_eq($sformatf("pipe_d1_%0d", k), rdata1, pd[k]);
      check_eq($sformatf("pipe_v2_%0d", k), rvalid2, (k >= 1 && k <= 3) ? 1 : 0);
      if (k >= 1 && k <= 3) check_eq($sformatf("pipe_d2_%0d", k), rdata2, pd[k-1]);
    end

    // clken low mid-pipeline
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = 0;
    step();
    address = 1;
    step();
    idle();
    clken = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq($sformatf("stall_v1_%0d", k), rvalid1, 1);
      check_eq($sformatf("stall_d1_%0d", k), rdata1, pd[1]);
      check_eq($sformatf("stall_v2_%0d", k), rvalid2, 1);
      check_eq($sformatf("stall_d2_%0d", k), rdata2, pd[0]);
    end
    clken = 1'b1;
    step();
    check_eq("resume_v1", rvalid1, 0);
    check_eq("resume_v2", rvalid2, 1);
    check_eq("resume_d2", rdata2, pd[1]);
    step();
    check_eq("resume_v2_end", rvalid2, 0);

    // Out-of-range word
    wr(AW'(9999), 32'hCAFE_F00D, 4'b1111);
    wr(AW'(10000), 32'h1234_5678, 4'b1111);
    rd_check("oor", AW'(10000), 32'h0, 2'b10);
    rd_check("keep9999", AW'(9999), 32'hCAFE_F00D, 2'b00);

    // Reset with a read in flight
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = 3;
    step();
    idle();
    reset_n = 1'b0;
    #1;
    check_eq("inflight_v1", rvalid1, 0);
    check_eq("inflight_d1", rdata1, 0);
    check_eq("inflight_v2", rvalid2, 0);
    step();
    reset_n = 1'b1;
    step();
    check_eq("inflight_v1_post", rvalid1, 0);
    check_eq("inflight_v2_post", rvalid2, 0);

`ifdef ONCHIP_RAM_INIT_CLEAR_EN
    count_busy(n);
    check_eq("clr_after_rst", n, DEPTH - 1);
    // Reset pulsed at clear count 7 restarts the full fill
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    repeat (7) step();
    reset_n = 1'b0;
    #1;
    check_eq("mid_busy", busy1, 1);
    check_eq("mid_v1", rvalid1, 0);
    check_eq("mid_v2", rvalid2, 0);
    step();
    reset_n = 1'b1;
    count_busy(n);
    check_eq("mid_cycles", n, DEPTH);
    check_eq("mid_v1_end", rvalid1, 0);
    check_eq("mid_v2_end", rvalid2, 0);
`else
    rd_check("keep_after_rst", 3, 32'h5566_7788, 2'b00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
